// File: rtl/axi_lite_mem_arbiter_pkg.sv
// Shared types for the AXI-lite memory arbiter: grant state encoding and response codes.
package axi_lite_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_IF_RD = 2'd1,
    ARB_LS_RD = 2'd2,
    ARB_LS_WR = 2'd3
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  function automatic logic is_read_state(arb_state_e s);
    return (s == ARB_IF_RD) || (s == ARB_LS_RD);
  endfunction

endpackage

// File: rtl/axi_lite_mem_arbiter_grant_fsm.sv
// Grant state machine for the arbiter: holds the owner from grant until the response
// handshake and tracks which address/data handshakes of the current transaction are done.
module axi_lite_mem_arbiter_grant_fsm
  import axi_lite_mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ls_awvalid,
  input  logic       ls_wvalid,
  input  logic       ls_arvalid,
  input  logic       if_arvalid,
  input  logic       ar_hs,
  input  logic       aw_hs,
  input  logic       w_hs,
  input  logic       r_hs,
  input  logic       b_hs,
  output arb_state_e state,
  output logic       ar_done,
  output logic       aw_done,
  output logic       w_done
);

  arb_state_e state_next;
  logic       ar_done_next;
  logic       aw_done_next;
  logic       w_done_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ARB_IDLE;
      ar_done <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_next;
      ar_done <= ar_done_next;
      aw_done <= aw_done_next;
      w_done  <= w_done_next;
    end
  end

  always_comb begin
    state_next   = state;
    ar_done_next = ar_done;
    aw_done_next = aw_done;
    w_done_next  = w_done;
    case (state)
      ARB_IDLE: begin
        // A write is only started once both AW and W are offered together.
        if (ls_awvalid && ls_wvalid) state_next = ARB_LS_WR;
        else if (ls_arvalid)         state_next = ARB_LS_RD;
        else if (if_arvalid)         state_next = ARB_IF_RD;
      end
      ARB_IF_RD, ARB_LS_RD: begin
        if (ar_hs) ar_done_next = 1'b1;
        if (r_hs)  state_next   = ARB_IDLE;
      end
      ARB_LS_WR: begin
        if (aw_hs) aw_done_next = 1'b1;
        if (w_hs)  w_done_next  = 1'b1;
        if (b_hs)  state_next   = ARB_IDLE;
      end
      default: state_next = ARB_IDLE;
    endcase
    if (state_next == ARB_IDLE) begin
      ar_done_next = 1'b0;
      aw_done_next = 1'b0;
      w_done_next  = 1'b0;
    end
  end

endmodule

// File: rtl/axi_lite_mem_arbiter.sv
// Shares one AXI-lite memory slave between the IFU (read only) and the LSU (read/write).
// Handshake rule on every channel: a beat transfers on a clock edge where valid and ready are both 1.
module axi_lite_mem_arbiter
  import axi_lite_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  // IFU read channel
  input  logic              if_arvalid,
  input  logic [ADDR_W-1:0] if_araddr,
  output logic              if_arready,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              if_rready,
  // LSU read channel
  input  logic              ls_arvalid,
  input  logic [ADDR_W-1:0] ls_araddr,
  output logic              ls_arready,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  input  logic              ls_rready,
  // LSU write channel
  input  logic              ls_awvalid,
  input  logic [ADDR_W-1:0] ls_awaddr,
  output logic              ls_awready,
  input  logic              ls_wvalid,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [STRB_W-1:0] ls_wstrb,
  output logic              ls_wready,
  output logic              ls_bvalid,
  output logic [1:0]        ls_bresp,
  input  logic              ls_bready,
  // Memory slave side
  output logic              m_arvalid,
  output logic [ADDR_W-1:0] m_araddr,
  input  logic              m_arready,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              m_rready,
  output logic              m_awvalid,
  output logic [ADDR_W-1:0] m_awaddr,
  input  logic              m_awready,
  output logic              m_wvalid,
  output logic [DATA_W-1:0] m_wdata,
  output logic [STRB_W-1:0] m_wstrb,
  input  logic              m_wready,
  input  logic              m_bvalid,
  input  logic [1:0]        m_bresp,
  output logic              m_bready,
  // Current grant, for observation
  output arb_state_e        state
);

  logic ar_done;
  logic aw_done;
  logic w_done;
  logic ar_hs;
  logic aw_hs;
  logic w_hs;
  logic r_hs;
  logic b_hs;

  assign ar_hs = m_arvalid & m_arready;
  assign aw_hs = m_awvalid & m_awready;
  assign w_hs  = m_wvalid & m_wready;
  assign r_hs  = m_rvalid & m_rready;
  assign b_hs  = m_bvalid & m_bready;

  axi_lite_mem_arbiter_grant_fsm u_grant_fsm (
    .clk        (clk),
    .rst        (rst),
    .ls_awvalid (ls_awvalid),
    .ls_wvalid  (ls_wvalid),
    .ls_arvalid (ls_arvalid),
    .if_arvalid (if_arvalid),
    .ar_hs      (ar_hs),
    .aw_hs      (aw_hs),
    .w_hs       (w_hs),
    .r_hs       (r_hs),
    .b_hs       (b_hs),
    .state      (state),
    .ar_done    (ar_done),
    .aw_done    (aw_done),
    .w_done     (w_done)
  );

  // Slave-side valids depend only on registered state and master valids, never on m_*ready.
  always_comb begin
    if_arready = 1'b0;
    if_rvalid  = 1'b0;
    if_rdata   = '0;
    ls_arready = 1'b0;
    ls_rvalid  = 1'b0;
    ls_rdata   = '0;
    ls_awready = 1'b0;
    ls_wready  = 1'b0;
    ls_bvalid  = 1'b0;
    ls_bresp   = '0;
    m_arvalid  = 1'b0;
    m_araddr   = '0;
    m_rready   = 1'b0;
    m_awvalid  = 1'b0;
    m_awaddr   = '0;
    m_wvalid   = 1'b0;
    m_wdata    = '0;
    m_wstrb    = '0;
    m_bready   = 1'b0;
    case (state)
      ARB_IF_RD: begin
        m_arvalid  = if_arvalid & ~ar_done;
        m_araddr   = if_araddr;
        if_arready = m_arready & ~ar_done;
        if_rvalid  = m_rvalid;
        if_rdata   = m_rdata;
        m_rready   = if_rready;
      end
      ARB_LS_RD: begin
        m_arvalid  = ls_arvalid & ~ar_done;
        m_araddr   = ls_araddr;
        ls_arready = m_arready & ~ar_done;
        ls_rvalid  = m_rvalid;
        ls_rdata   = m_rdata;
        m_rready   = ls_rready;
      end
      ARB_LS_WR: begin
        m_awvalid  = ls_awvalid & ~aw_done;
        m_awaddr   = ls_awaddr;
        ls_awready = m_awready & ~aw_done;
        m_wvalid   = ls_wvalid & ~w_done;
        m_wdata    = ls_wdata;
        m_wstrb    = ls_wstrb;
        ls_wready  = m_wready & ~w_done;
        ls_bvalid  = m_bvalid;
        ls_bresp   = m_bresp;
        m_bready   = ls_bready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_mem_arbiter.sv
// Directed bench for axi_lite_mem_arbiter: arbitration vector table plus multi-cycle sequences.
module tb_axi_lite_mem_arbiter;
  import axi_lite_mem_arbiter_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int STRB_W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              if_arvalid, if_arready, if_rvalid, if_rready;
  logic [ADDR_W-1:0] if_araddr;
  logic [DATA_W-1:0] if_rdata;
  logic              ls_arvalid, ls_arready, ls_rvalid, ls_rready;
  logic [ADDR_W-1:0] ls_araddr;
  logic [DATA_W-1:0] ls_rdata;
  logic              ls_awvalid, ls_awready, ls_wvalid, ls_wready, ls_bvalid, ls_bready;
  logic [ADDR_W-1:0] ls_awaddr;
  logic [DATA_W-1:0] ls_wdata;
  logic [STRB_W-1:0] ls_wstrb;
  logic [1:0]        ls_bresp;
  logic              m_arvalid, m_arready, m_rvalid, m_rready;
  logic [ADDR_W-1:0] m_araddr;
  logic [DATA_W-1:0] m_rdata;
  logic              m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [ADDR_W-1:0] m_awaddr;
  logic [DATA_W-1:0] m_wdata;
  logic [STRB_W-1:0] m_wstrb;
  logic [1:0]        m_bresp;
  arb_state_e        state;

  axi_lite_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W)) dut (
    .clk(clk), .rst(rst),
    .if_arvalid(if_arvalid), .if_araddr(if_araddr), .if_arready(if_arready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_rready(if_rready),
    .ls_arvalid(ls_arvalid), .ls_araddr(ls_araddr), .ls_arready(ls_arready),
    .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_rready(ls_rready),
    .ls_awvalid(ls_awvalid), .ls_awaddr(ls_awaddr), .ls_awready(ls_awready),
    .ls_wvalid(ls_wvalid), .ls_wdata(ls_wdata), .ls_wstrb(ls_wstrb), .ls_wready(ls_wready),
    .ls_bvalid(ls_bvalid), .ls_bresp(ls_bresp), .ls_bready(ls_bready),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rready(m_rready),
    .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awready(m_awready),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
    .state(state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q[$];
  int ar_hs_cnt = 0;
  int aw_hs_cnt = 0;
  int w_hs_cnt  = 0;

  always @(posedge clk) begin
    if (!rst) begin
      if (m_arvalid && m_arready) ar_hs_cnt++;
      if (m_awvalid && m_awready) aw_hs_cnt++;
      if (m_wvalid && m_wready)   w_hs_cnt++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_all();
    if_arvalid = 0; if_araddr = '0; if_rready = 0;
    ls_arvalid = 0; ls_araddr = '0; ls_rready = 0;
    ls_awvalid = 0; ls_awaddr = '0; ls_wvalid = 0; ls_wdata = '0; ls_wstrb = '0; ls_bready = 0;
    m_arready = 0; m_rvalid = 0; m_rdata = '0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = '0;
  endtask

  // Complete whatever transaction was granted, with a zero-wait slave.
  task automatic finish_txn(input arb_state_e s, input string name);
    if (s == ARB_IF_RD || s == ARB_LS_RD) begin
      m_arready = 1;
      tick();
      idle_all();
      m_rvalid = 1; if_rready = 1; ls_rready = 1;
      tick();
    end else if (s == ARB_LS_WR) begin
      m_awready = 1; m_wready = 1;
      tick();
      idle_all();
      m_bvalid = 1; ls_bready = 1;
      tick();
    end else begin
      idle_all();
      tick();
    end
    idle_all();
    settle();
    chk($sformatf("%s_done_idle", name), 64'(state), 64'(ARB_IDLE));
  endtask

  // Full IFU read starting from IDLE, checking grant latency, data and return.
  task automatic if_read(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                         input string name);
    if_arvalid = 1; if_araddr = addr;
    settle();
    chk({name, "_pre_idle"}, 64'(state), 64'(ARB_IDLE));
    chk({name, "_no_ar_yet"}, 64'(m_arvalid), 64'd0);
    tick();
    chk({name, "_grant"}, 64'(state), 64'(ARB_IF_RD));
    chk({name, "_m_arvalid"}, 64'(m_arvalid), 64'd1);
    chk({name, "_m_araddr"}, 64'(m_araddr), 64'(addr));
    m_arready = 1;
    settle();
    chk({name, "_if_arready"}, 64'(if_arready), 64'd1);
    tick();
    if_arvalid = 0; m_arready = 0;
    m_rvalid = 1; m_rdata = data; if_rready = 1;
    exp_q.push_back(data);
    settle();
    chk({name, "_ar_dropped"}, 64'(m_arvalid), 64'd0);
    chk({name, "_if_rvalid"}, 64'(if_rvalid), 64'd1);
    chk({name, "_if_rdata"}, 64'(if_rdata), 64'(exp_q.pop_front()));
    tick();
    m_rvalid = 0; m_rdata = '0; if_rready = 0;
    settle();
    chk({name, "_back_idle"}, 64'(state), 64'(ARB_IDLE));
    chk({name, "_if_rvalid_off"}, 64'(if_rvalid), 64'd0);
  endtask

  typedef struct {
    string      name;
    logic       aw;
    logic       w;
    logic       lar;
    logic       iar;
    arb_state_e exp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int snap_aw, snap_w, snap_ar;
    logic [ADDR_W-1:0] exp_araddr;

    vecs[0] = '{"all_req",   1'b1, 1'b1, 1'b1, 1'b1, ARB_LS_WR};
    vecs[1] = '{"aw_only",   1'b1, 1'b0, 1'b1, 1'b1, ARB_LS_RD};
    vecs[2] = '{"w_only",    1'b0, 1'b1, 1'b0, 1'b1, ARB_IF_RD};
    vecs[3] = '{"ls_rd",     1'b0, 1'b0, 1'b1, 1'b0, ARB_LS_RD};
    vecs[4] = '{"if_rd",     1'b0, 1'b0, 1'b0, 1'b1, ARB_IF_RD};
    vecs[5] = '{"aw_alone",  1'b1, 1'b0, 1'b0, 1'b0, ARB_IDLE};
    vecs[6] = '{"none",      1'b0, 1'b0, 1'b0, 1'b0, ARB_IDLE};

    // Reset state
    rst = 1;
    idle_all();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_state", 64'(state), 64'(ARB_IDLE));
    chk("rst_m_arvalid", 64'(m_arvalid), 64'd0);
    chk("rst_m_awvalid", 64'(m_awvalid), 64'd0);
    chk("rst_m_wvalid", 64'(m_wvalid), 64'd0);
    chk("rst_if_arready", 64'(if_arready), 64'd0);
    chk("rst_ls_bvalid", 64'(ls_bvalid), 64'd0);
    chk("rst_m_araddr", 64'(m_araddr), 64'd0);
    rst = 0;

    // Arbitration priority table
    for (int i = 0; i < 7; i++) begin
      ls_awvalid = vecs[i].aw; ls_wvalid = vecs[i].w;
      ls_arvalid = vecs[i].lar; if_arvalid = vecs[i].iar;
      if_araddr = 32'h100; ls_araddr = 32'h200; ls_awaddr = 32'h300;
      settle();
      chk($sformatf("%s_pre_idle", vecs[i].name), 64'(state), 64'(ARB_IDLE));
      tick();
      exp_araddr = (vecs[i].exp == ARB_IF_RD) ? 32'h100 :
                   (vecs[i].exp == ARB_LS_RD) ? 32'h200 : 32'h0;
      chk($sformatf("%s_state", vecs[i].name), 64'(state), 64'(vecs[i].exp));
      chk($sformatf("%s_m_arvalid", vecs[i].name), 64'(m_arvalid),
          64'(vecs[i].exp == ARB_IF_RD || vecs[i].exp == ARB_LS_RD));
      chk($sformatf("%s_m_awvalid", vecs[i].name), 64'(m_awvalid), 64'(vecs[i].exp == ARB_LS_WR));
      chk($sformatf("%s_m_wvalid", vecs[i].name), 64'(m_wvalid), 64'(vecs[i].exp == ARB_LS_WR));
      chk($sformatf("%s_m_araddr", vecs[i].name), 64'(m_araddr), 64'(exp_araddr));
      finish_txn(vecs[i].exp, vecs[i].name);
    end

    // 1: lone IFU read
    if_read(32'h8000_0000, 64'h0000_0013_0010_0093, "t1");

    // 2: IFU and LSU read in the same cycle
    if_arvalid = 1; if_araddr = 32'h8000_0008;
    ls_arvalid = 1; ls_araddr = 32'h8000_2000;
    tick();
    chk("t2_ls_first", 64'(state), 64'(ARB_LS_RD));
    m_arready = 1;
    settle();
    chk("t2_ls_arready", 64'(ls_arready), 64'd1);
    chk("t2_if_arready_blocked", 64'(if_arready), 64'd0);
    tick();
    ls_arvalid = 0; m_arready = 0;
    m_rvalid = 1; m_rdata = 64'h1111_2222_3333_4444; ls_rready = 1;
    exp_q.push_back(64'h1111_2222_3333_4444);
    settle();
    chk("t2_ls_rdata", 64'(ls_rdata), 64'(exp_q.pop_front()));
    chk("t2_if_rvalid_off", 64'(if_rvalid), 64'd0);
    chk("t2_if_arready_still0", 64'(if_arready), 64'd0);
    tick();
    m_rvalid = 0; m_rdata = '0; ls_rready = 0;
    if_read(32'h8000_0008, 64'h5555_6666_7777_8888, "t2_if");

    // 3: LSU write, slave takes AW two cycles before W
    snap_aw = aw_hs_cnt; snap_w = w_hs_cnt;
    ls_awvalid = 1; ls_awaddr = 32'h8000_1000;
    ls_wvalid = 1; ls_wdata = 64'h0000_0000_dead_beef; ls_wstrb = 8'h0f; ls_bready = 1;
    tick();
    chk("t3_grant", 64'(state), 64'(ARB_LS_WR));
    m_awready = 1;
    settle();
    chk("t3_ls_awready", 64'(ls_awready), 64'd1);
    chk("t3_ls_wready_wait", 64'(ls_wready), 64'd0);
    chk("t3_m_wdata", 64'(m_wdata), 64'h0000_0000_dead_beef);
    chk("t3_m_wstrb", 64'(m_wstrb), 64'h0f);
    chk("t3_m_awaddr", 64'(m_awaddr), 64'h8000_1000);
    tick();
    ls_awvalid = 0; m_awready = 0;
    settle();
    chk("t3_aw_dropped", 64'(m_awvalid), 64'd0);
    chk("t3_w_held", 64'(m_wvalid), 64'd1);
    tick();
    m_wready = 1;
    settle();
    chk("t3_ls_wready", 64'(ls_wready), 64'd1);
    tick();
    ls_wvalid = 0; m_wready = 0;
    m_bvalid = 1; m_bresp = RESP_OKAY;
    settle();
    chk("t3_w_dropped", 64'(m_wvalid), 64'd0);
    chk("t3_ls_bvalid", 64'(ls_bvalid), 64'd1);
    chk("t3_ls_bresp", 64'(ls_bresp), 64'(RESP_OKAY));
    chk("t3_m_bready", 64'(m_bready), 64'd1);
    tick();
    idle_all();
    settle();
    chk("t3_back_idle", 64'(state), 64'(ARB_IDLE));
    chk("t3_aw_count", 64'(aw_hs_cnt - snap_aw), 64'd1);
    chk("t3_w_count", 64'(w_hs_cnt - snap_w), 64'd1);

    // 4: IFU read with 3 cycles of R backpressure
    snap_ar = ar_hs_cnt;
    if_arvalid = 1; if_araddr = 32'h8000_0010;
    tick();
    m_arready = 1;
    tick();
    if_arvalid = 0; m_arready = 0;
    m_rvalid = 1; m_rdata = 64'hcafe_f00d_1234_5678; if_rready = 0;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk($sformatf("t4_rvalid_%0d", c), 64'(if_rvalid), 64'd1);
      chk($sformatf("t4_rdata_%0d", c), 64'(if_rdata), 64'hcafe_f00d_1234_5678);
      chk($sformatf("t4_m_rready_%0d", c), 64'(m_rready), 64'd0);
      chk($sformatf("t4_no_ar_%0d", c), 64'(m_arvalid), 64'd0);
      chk($sformatf("t4_state_%0d", c), 64'(state), 64'(ARB_IF_RD));
      tick();
    end
    if_rready = 1;
    settle();
    chk("t4_m_rready", 64'(m_rready), 64'd1);
    tick();
    idle_all();
    settle();
    chk("t4_back_idle", 64'(state), 64'(ARB_IDLE));
    chk("t4_single_ar", 64'(ar_hs_cnt - snap_ar), 64'd1);

    // 5: reset during LS_WR after only AW completed
    ls_awvalid = 1; ls_awaddr = 32'h8000_3000;
    ls_wvalid = 1; ls_wdata = 64'h99; ls_wstrb = 8'hff; ls_bready = 1;
    tick();
    m_awready = 1;
    tick();
    m_awready = 0;
    settle();
    chk("t5_aw_done", 64'(m_awvalid), 64'd0);
    chk("t5_w_pending", 64'(m_wvalid), 64'd1);
    rst = 1;
    tick();
    chk("t5_rst_state", 64'(state), 64'(ARB_IDLE));
    chk("t5_rst_m_wvalid", 64'(m_wvalid), 64'd0);
    chk("t5_rst_ls_wready", 64'(ls_wready), 64'd0);
    chk("t5_rst_m_awvalid", 64'(m_awvalid), 64'd0);
    chk("t5_rst_m_wdata", 64'(m_wdata), 64'd0);
    chk("t5_rst_ls_bvalid", 64'(ls_bvalid), 64'd0);
    rst = 0;
    idle_all();
    if_read(32'h8000_0020, 64'h0bad_c0de_0bad_c0de, "t5_if");
    ls_awvalid = 1; ls_awaddr = 32'h8000_3008;
    ls_wvalid = 1; ls_wdata = 64'h77; ls_wstrb = 8'h01;
    tick();
    chk("t5_new_wr_aw", 64'(m_awvalid), 64'd1);
    chk("t5_new_wr_w", 64'(m_wvalid), 64'd1);
    finish_txn(ARB_LS_WR, "t5_wr");

    // 6: 10 back-to-back LSU reads starve a pending IFU read
    if_arvalid = 1; if_araddr = 32'h8000_0040;
    ls_arvalid = 1;
    for (int i = 0; i < 10; i++) begin
      ls_araddr = 32'h8000_2000 + 32'(i * 8);
      settle();
      chk($sformatf("t6_idle_%0d", i), 64'(state), 64'(ARB_IDLE));
      tick();
      chk($sformatf("t6_ls_grant_%0d", i), 64'(state), 64'(ARB_LS_RD));
      chk($sformatf("t6_araddr_%0d", i), 64'(m_araddr), 64'(32'h8000_2000 + 32'(i * 8)));
      m_arready = 1;
      settle();
      chk($sformatf("t6_if_blocked_%0d", i), 64'(if_arready), 64'd0);
      tick();
      m_arready = 0;
      if (i == 9) ls_arvalid = 0;
      m_rvalid = 1; m_rdata = 64'h1000 + 64'(i); ls_rready = 1;
      exp_q.push_back(64'h1000 + 64'(i));
      settle();
      chk($sformatf("t6_rdata_%0d", i), 64'(ls_rdata), 64'(exp_q.pop_front()));
      tick();
      m_rvalid = 0; ls_rready = 0;
    end
    if_read(32'h8000_0040, 64'hfeed_face_0000_0040, "t6_if");

    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
